ssm_fetch_sched: RTL and testbench

Fetch scheduler for the decoder's substream (SSM) funnel shifters. It pops 128-bit words from the shared compressed-data source and steers each word to one of `NUM_SSM` substream shifters. It tracks per-substream fullness and primes every shifter before parsing starts. It sits between the codec data FIFO and the substream parsers, and replaces the per-parser self-fetch logic so several parsers can share one data port.

---
 rtl/ssm_fetch_sched_if.sv | 26 ++
 rtl/ssm_fetch_sched.sv | 161 ++++++++++++++++
 tb/tb_ssm_fetch_sched.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ssm_fetch_sched_if.sv
// Bus bundle between the compressed-data source, the fetch scheduler and the
// substream shifters; master is the scheduler side, slave is the environment side.
interface ssm_fetch_sched_if #(
    parameter int NUM_SSM = 4,
    parameter int WORD_W  = 128,
    parameter int FULL_W  = 8
);
    logic                        codec_data_vld;
    logic [WORD_W-1:0]           codec_data;
    logic                        codec_data_rd_en;
    logic [NUM_SSM-1:0]          ssm_consume_en;
    logic [NUM_SSM*8-1:0]        ssm_consume_bits;
    logic [NUM_SSM-1:0]          ssm_wr_en;
    logic [WORD_W-1:0]           ssm_wr_data;
    logic [NUM_SSM*FULL_W-1:0]   ssm_fullness;

    modport master (
        input  codec_data_vld, codec_data, ssm_consume_en, ssm_consume_bits,
        output codec_data_rd_en, ssm_wr_en, ssm_wr_data, ssm_fullness
    );

    modport slave (
        output codec_data_vld, codec_data, ssm_consume_en, ssm_consume_bits,
        input  codec_data_rd_en, ssm_wr_en, ssm_wr_data, ssm_fullness
    );
endinterface

// File: rtl/ssm_fetch_sched.sv
// Shared fetch scheduler: pops source words and steers each one to a substream
// shifter, priming all shifters in order before switching to round-robin refill.
module ssm_fetch_sched #(
    parameter int NUM_SSM = 4,
    parameter int WORD_W  = 128,
    parameter int SE_MAX  = 128,
    parameter int FULL_W  = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic                    flush,
    ssm_fetch_sched_if.master       bus,
    output logic                    parse_ready,
    output logic                    err_underflow
);

    localparam int PTR_W = $clog2(NUM_SSM);
    localparam int SUM_W = FULL_W + 1;

    typedef enum logic [1:0] {IDLE, PRIME, RUN} stateT;

    stateT              state, stateNext;
    logic [FULL_W-1:0]  fullness     [NUM_SSM];
    logic [FULL_W-1:0]  fullnessNext [NUM_SSM];
    logic [PTR_W-1:0]   rrPtr, rrPtrNext, grantIdx;
    logic [NUM_SSM-1:0] req, eligible, grantOneHot, wrEn;
    logic [WORD_W-1:0]  wrData;
    logic               grantFound, popEn, errNext, allFullNext;

    always_comb begin
        for (int i = 0; i < NUM_SSM; i++) begin
            req[i] = fullness[i] < FULL_W'(SE_MAX);
        end
    end

    // Priming fills strictly in index order, so only the lowest requester is eligible.
    always_comb begin
        eligible = '0;
        if (state == RUN) begin
            eligible = req;
        end else if (state == PRIME) begin
            eligible = req & (~req + NUM_SSM'(1));
        end
    end

    always_comb begin
        int cand;
        cand       = 0;
        grantIdx   = '0;
        grantFound = 1'b0;
        for (int k = 0; k < NUM_SSM; k++) begin
            cand = int'(rrPtr) + k;
            if (cand >= NUM_SSM) begin
                cand = cand - NUM_SSM;
            end
            if (!grantFound && eligible[PTR_W'(cand)]) begin
                grantFound = 1'b1;
                grantIdx   = PTR_W'(cand);
            end
        end
    end

    always_comb begin
        popEn       = (state != IDLE) && bus.codec_data_vld && grantFound && !flush;
        grantOneHot = popEn ? (NUM_SSM'(1) << grantIdx) : '0;
        rrPtrNext   = rrPtr;
        if (popEn) begin
            rrPtrNext = (grantIdx == PTR_W'(NUM_SSM - 1)) ? '0 : grantIdx + PTR_W'(1);
        end
    end

    // A grant only ever lands on a lane below SE_MAX, so add-then-subtract never exceeds 2*SE_MAX-1.
    always_comb begin
        logic [SUM_W-1:0] sum;
        logic [7:0]       cons;
        sum         = '0;
        cons        = '0;
        errNext     = err_underflow;
        allFullNext = 1'b1;
        for (int i = 0; i < NUM_SSM; i++) begin
            cons = bus.ssm_consume_bits[8*i +: 8];
            sum  = {1'b0, fullness[i]} + (grantOneHot[i] ? SUM_W'(WORD_W) : SUM_W'(0));
            if (bus.ssm_consume_en[i]) begin
                if (state != RUN) begin
                    errNext = 1'b1;
                end else if (SUM_W'(cons) > sum) begin
                    sum     = '0;
                    errNext = 1'b1;
                end else begin
                    sum = sum - SUM_W'(cons);
                end
            end
            fullnessNext[i] = sum[FULL_W-1:0];
            if (sum < SUM_W'(SE_MAX)) begin
                allFullNext = 1'b0;
            end
        end
    end

    always_comb begin
        stateNext = state;
        if (flush) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE:    if (start)       stateNext = PRIME;
                PRIME:   if (allFullNext) stateNext = RUN;
                RUN:     stateNext = RUN;
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rrPtr         <= '0;
            err_underflow <= 1'b0;
            wrEn          <= '0;
            wrData        <= '0;
            for (int i = 0; i < NUM_SSM; i++) begin
                fullness[i] <= '0;
            end
        end else if (flush) begin
            rrPtr         <= '0;
            err_underflow <= 1'b0;
            wrEn          <= '0;
            for (int i = 0; i < NUM_SSM; i++) begin
                fullness[i] <= '0;
            end
        end else begin
            rrPtr         <= rrPtrNext;
            err_underflow <= errNext;
            wrEn          <= grantOneHot;
            if (popEn) begin
                wrData <= bus.codec_data;
            end
            for (int i = 0; i < NUM_SSM; i++) begin
                fullness[i] <= fullnessNext[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_SSM; g++) begin : genFull
        assign bus.ssm_fullness[g*FULL_W +: FULL_W] = fullness[g];
    end

    assign bus.codec_data_rd_en = popEn;
    assign bus.ssm_wr_en        = wrEn;
    assign bus.ssm_wr_data      = wrData;
    assign parse_ready          = (state == RUN);

endmodule

// File: tb/tb_ssm_fetch_sched.sv
// Self-checking bench for ssm_fetch_sched: a per-cycle vector table plus a
// scoreboard that matches each expected pop against the shifter write one cycle later.
module tb_ssm_fetch_sched;

    localparam int NUM_SSM = 4;
    localparam int WORD_W  = 128;
    localparam int FULL_W  = 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0;
    logic flush = 1'b0;
    logic parseReady, errUnderflow;

    ssm_fetch_sched_if #(.NUM_SSM(NUM_SSM), .WORD_W(WORD_W), .FULL_W(FULL_W)) bus();

    ssm_fetch_sched #(.NUM_SSM(NUM_SSM), .WORD_W(WORD_W), .SE_MAX(128), .FULL_W(FULL_W)) dut (
        .clk(clk),
        .rstn(rstn),
        .start(start),
        .flush(flush),
        .bus(bus),
        .parse_ready(parseReady),
        .err_underflow(errUnderflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        flush;
        logic        vld;
        logic [3:0]  cEn;
        logic [7:0]  cBits;
        logic        expRd;
        int          expLane;
        logic [31:0] expFull;
        logic        expReady;
        logic        expErr;
    } vecT;

    typedef struct {
        int           due;
        logic [3:0]   en;
        logic [127:0] data;
    } wrT;

    vecT vecs[$];
    wrT  sb[$];
    int  cycle = 0;
    int  nCompared = 0;
    int  nMismatch = 0;
    bit  monitorOn = 0;

    always @(posedge clk) cycle++;

    function automatic logic [127:0] mkWord(int n);
        return {32'(n), 32'hC0DE0000 ^ 32'(n), ~32'(n), 32'h12345678 + 32'(n)};
    endfunction

    function automatic logic [31:0] fl(int f0, int f1, int f2, int f3);
        return {8'(f3), 8'(f2), 8'(f1), 8'(f0)};
    endfunction

    task automatic compareVal(string name, logic [127:0] act, logic [127:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic addVec(logic s, logic f, logic v, logic [3:0] cEn, int bits,
                          logic rd, int lane, logic [31:0] full, logic rdy, logic err);
        vecT t;
        t.start = s; t.flush = f; t.vld = v; t.cEn = cEn; t.cBits = 8'(bits);
        t.expRd = rd; t.expLane = lane; t.expFull = full; t.expReady = rdy; t.expErr = err;
        vecs.push_back(t);
    endtask

    task automatic checkOutput(vecT v, int idx);
        wrT e;
        compareVal($sformatf("rd_en v%0d", idx), 128'(bus.codec_data_rd_en), 128'(v.expRd));
        compareVal($sformatf("fullness v%0d", idx), 128'(bus.ssm_fullness), 128'(v.expFull));
        compareVal($sformatf("parse_ready v%0d", idx), 128'(parseReady), 128'(v.expReady));
        compareVal($sformatf("err_underflow v%0d", idx), 128'(errUnderflow), 128'(v.expErr));
        if (v.expRd) begin
            e.due  = cycle + 1;
            e.en   = 4'b0001 << v.expLane;
            e.data = mkWord(idx);
            sb.push_back(e);
        end
    endtask

    task automatic applyStimulus(vecT v, int idx);
        start                = v.start;
        flush                = v.flush;
        bus.codec_data_vld   = v.vld;
        bus.codec_data       = mkWord(idx);
        bus.ssm_consume_en   = v.cEn;
        bus.ssm_consume_bits = {4{v.cBits}};
        @(negedge clk);
        checkOutput(v, idx);
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
    endtask

    // Every cycle either retires the due scoreboard entry or must show no write.
    always @(negedge clk) begin
        wrT e;
        if (rstn && monitorOn) begin
            if (sb.size() > 0 && sb[0].due == cycle) begin
                e = sb.pop_front();
                compareVal($sformatf("wr_en c%0d", cycle), 128'(bus.ssm_wr_en), 128'(e.en));
                compareVal($sformatf("wr_data c%0d", cycle), bus.ssm_wr_data, e.data);
            end else begin
                compareVal($sformatf("wr_en idle c%0d", cycle), 128'(bus.ssm_wr_en), 128'(0));
            end
        end
    end

    initial begin
        vecT h;
        bus.codec_data_vld   = 1'b0;
        bus.codec_data       = '0;
        bus.ssm_consume_en   = '0;
        bus.ssm_consume_bits = '0;

        repeat (2) @(negedge clk);
        compareVal("reset rd_en", 128'(bus.codec_data_rd_en), 128'(0));
        compareVal("reset wr_en", 128'(bus.ssm_wr_en), 128'(0));
        compareVal("reset wr_data", bus.ssm_wr_data, 128'(0));
        compareVal("reset fullness", 128'(bus.ssm_fullness), 128'(0));
        compareVal("reset parse_ready", 128'(parseReady), 128'(0));
        compareVal("reset err_underflow", 128'(errUnderflow), 128'(0));
        @(posedge clk);
        #1;
        rstn      = 1'b1;
        monitorOn = 1;

        //     start flush vld cEn     bits rd lane fullness(0,1,2,3)         rdy err
        addVec(1, 0, 1, 4'b0000,   0, 0, 0, fl(  0,  0,  0,  0), 0, 0);  // c0
        addVec(0, 0, 1, 4'b0000,   0, 1, 0, fl(  0,  0,  0,  0), 0, 0);
        addVec(0, 0, 1, 4'b0000,   0, 1, 1, fl(128,  0,  0,  0), 0, 0);
        addVec(0, 0, 1, 4'b0000,   0, 1, 2, fl(128,128,  0,  0), 0, 0);
        addVec(0, 0, 1, 4'b0000,   0, 1, 3, fl(128,128,128,  0), 0, 0);
        addVec(0, 0, 1, 4'b0010,  40, 0, 0, fl(128,128,128,128), 1, 0);  // c5
        addVec(0, 0, 1, 4'b0010,  40, 1, 1, fl(128, 88,128,128), 1, 0);
        addVec(0, 0, 1, 4'b0001, 128, 0, 0, fl(128,176,128,128), 1, 0);
        addVec(0, 0, 1, 4'b0101,  28, 1, 0, fl(  0,176,128,128), 1, 0);
        addVec(0, 0, 1, 4'b0000,   0, 1, 2, fl(100,176,100,128), 1, 0);
        addVec(0, 0, 1, 4'b0000,   0, 1, 0, fl(100,176,228,128), 1, 0);  // c10
        addVec(0, 0, 0, 4'b1111, 128, 0, 0, fl(228,176,228,128), 1, 0);
        addVec(0, 0, 1, 4'b0000,   0, 1, 1, fl(100, 48,100,  0), 1, 0);
        addVec(0, 0, 1, 4'b0000,   0, 1, 2, fl(100,176,100,  0), 1, 0);
        addVec(0, 0, 1, 4'b0000,   0, 1, 3, fl(100,176,228,  0), 1, 0);
        addVec(0, 0, 1, 4'b0000,   0, 1, 0, fl(100,176,228,128), 1, 0);  // c15
        addVec(0, 0, 0, 4'b1000,  98, 0, 0, fl(228,176,228,128), 1, 0);
        addVec(0, 0, 0, 4'b1000,  50, 0, 0, fl(228,176,228, 30), 1, 0);
        addVec(0, 0, 0, 4'b0000,   0, 0, 0, fl(228,176,228,  0), 1, 1);
        addVec(0, 1, 1, 4'b0000,   0, 0, 0, fl(228,176,228,  0), 1, 1);
        addVec(1, 0, 0, 4'b0000,   0, 0, 0, fl(  0,  0,  0,  0), 0, 0);  // c20
        addVec(0, 0, 1, 4'b0000,   0, 1, 0, fl(  0,  0,  0,  0), 0, 0);
        addVec(0, 0, 0, 4'b0001,  10, 0, 0, fl(128,  0,  0,  0), 0, 0);
        addVec(0, 0, 1, 4'b0000,   0, 1, 1, fl(128,  0,  0,  0), 0, 1);
        addVec(0, 0, 0, 4'b0000,   0, 0, 0, fl(128,128,  0,  0), 0, 1);
        addVec(0, 0, 1, 4'b0000,   0, 1, 2, fl(128,128,  0,  0), 0, 1);  // c25
        addVec(0, 0, 1, 4'b0000,   0, 1, 3, fl(128,128,128,  0), 0, 1);
        addVec(0, 0, 1, 4'b0000,   0, 0, 0, fl(128,128,128,128), 1, 1);
        addVec(0, 1, 0, 4'b0000,   0, 0, 0, fl(128,128,128,128), 1, 1);
        addVec(0, 0, 0, 4'b0000,   0, 0, 0, fl(  0,  0,  0,  0), 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
        end

        compareVal("wr_data hold", bus.ssm_wr_data, mkWord(26));

        // Start, take one pop, then pull reset while that write is on the outputs.
        h = '{1'b1, 1'b0, 1'b0, 4'b0000, 8'd0, 1'b0, 0, fl(0,0,0,0), 1'b0, 1'b0};
        applyStimulus(h, 30);
        h = '{1'b0, 1'b0, 1'b1, 4'b0000, 8'd0, 1'b1, 0, fl(0,0,0,0), 1'b0, 1'b0};
        applyStimulus(h, 31);
        rstn = 1'b0;
        #1;
        compareVal("async reset wr_en", 128'(bus.ssm_wr_en), 128'(0));
        compareVal("async reset wr_data", bus.ssm_wr_data, 128'(0));
        compareVal("async reset fullness", 128'(bus.ssm_fullness), 128'(0));
        compareVal("async reset rd_en", 128'(bus.codec_data_rd_en), 128'(0));
        sb.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        h = '{1'b0, 1'b0, 1'b1, 4'b0000, 8'd0, 1'b0, 0, fl(0,0,0,0), 1'b0, 1'b0};
        applyStimulus(h, 32);

        compareVal("scoreboard drained", 128'(sb.size()), 128'(0));
        monitorOn = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
